// File: rtl/bus_register_bank.sv
// Host register-bus responder: synchronizes the BusClock strobe, decodes per-voice synth
// registers, commits 24-bit values atomically on their top byte and serves byte reads.
module bus_register_bank #(
  parameter int          NUM_VOICES   = 2,
  parameter logic [15:0] BASE_ADDR    = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [15:0]             BusAddress,
  inout  wire  [7:0]              BusData,
  input  logic                    BusReadWrite,
  input  logic                    BusClock,
  output logic [NUM_VOICES-1:0]   Gate,
  output logic [24*NUM_VOICES-1:0] Incr,
  output logic [2*NUM_VOICES-1:0] WaveType,
  output logic [24*NUM_VOICES-1:0] PulseWidth,
  output logic [24*NUM_VOICES-1:0] Attack,
  output logic [24*NUM_VOICES-1:0] Decay,
  output logic [24*NUM_VOICES-1:0] Release,
  output logic [24*NUM_VOICES-1:0] Sustain,
  output logic [NUM_VOICES-1:0]   Linear
);

  logic bclk_meta_reg, bclk_sync_reg, bclk_prev_reg, strobe_reg;
  logic [7:0] rdata_reg, rdata_next;
  logic mapped_reg, mapped_next;
  logic [NUM_VOICES-1:0] hit_vec;
  logic [8*NUM_VOICES-1:0] rbyte_flat;

  // Synchronizer presets high so a BusClock already high at reset release never looks
  // like a rising edge; only a fresh low-to-high transition produces a strobe.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bclk_meta_reg <= 1'b1;
      bclk_sync_reg <= 1'b1;
      bclk_prev_reg <= 1'b1;
      strobe_reg    <= 1'b0;
    end else begin
      bclk_meta_reg <= BusClock;
      bclk_sync_reg <= bclk_meta_reg;
      bclk_prev_reg <= bclk_sync_reg;
      strobe_reg    <= bclk_sync_reg & ~bclk_prev_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    localparam logic [15:0] VBASE = 16'(BASE_ADDR + gi * VOICE_STRIDE);

    logic [15:0] off;
    logic        hit;
    logic [2:0]  fld;
    logic [1:0]  bsel;
    logic [7:0]  rbyte_v;
    logic        gate_reg, linear_reg;
    logic [1:0]  wave_reg;
    logic [23:0] live_reg   [6];
    logic [15:0] shadow_reg [6];

    assign off = BusAddress - VBASE;
    assign hit = (BusAddress >= VBASE) && (off <= 16'h0014);

    // Wide field order: Incr, PulseWidth, Attack, Decay, Sustain, Release.
    always_comb begin
      fld  = 3'd0;
      bsel = 2'd0;
      case (off[4:0])
        5'd1:  {fld, bsel} = {3'd0, 2'd0};
        5'd2:  {fld, bsel} = {3'd0, 2'd1};
        5'd3:  {fld, bsel} = {3'd0, 2'd2};
        5'd5:  {fld, bsel} = {3'd1, 2'd0};
        5'd6:  {fld, bsel} = {3'd1, 2'd1};
        5'd7:  {fld, bsel} = {3'd1, 2'd2};
        5'd8:  {fld, bsel} = {3'd2, 2'd0};
        5'd9:  {fld, bsel} = {3'd2, 2'd1};
        5'd10: {fld, bsel} = {3'd2, 2'd2};
        5'd11: {fld, bsel} = {3'd3, 2'd0};
        5'd12: {fld, bsel} = {3'd3, 2'd1};
        5'd13: {fld, bsel} = {3'd3, 2'd2};
        5'd14: {fld, bsel} = {3'd4, 2'd0};
        5'd15: {fld, bsel} = {3'd4, 2'd1};
        5'd16: {fld, bsel} = {3'd4, 2'd2};
        5'd17: {fld, bsel} = {3'd5, 2'd0};
        5'd18: {fld, bsel} = {3'd5, 2'd1};
        5'd19: {fld, bsel} = {3'd5, 2'd2};
        default: {fld, bsel} = {3'd0, 2'd0};
      endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        gate_reg   <= 1'b0;
        wave_reg   <= 2'b00;
        linear_reg <= 1'b0;
        for (int i = 0; i < 6; i++) begin
          live_reg[i]   <= '0;
          shadow_reg[i] <= '0;
        end
      end else if (strobe_reg && BusReadWrite && hit) begin
        case (off[4:0])
          5'd0:  gate_reg   <= BusData[0];
          5'd4:  wave_reg   <= BusData[1:0];
          5'd20: linear_reg <= BusData[0];
          default: begin
            case (bsel)
              2'd0:    shadow_reg[fld][7:0]  <= BusData;
              2'd1:    shadow_reg[fld][15:8] <= BusData;
              default: live_reg[fld]         <= {BusData, shadow_reg[fld]};
            endcase
          end
        endcase
      end
    end

    always_comb begin
      rbyte_v = 8'h00;
      case (off[4:0])
        5'd0:  rbyte_v = {7'd0, gate_reg};
        5'd4:  rbyte_v = {6'd0, wave_reg};
        5'd20: rbyte_v = {7'd0, linear_reg};
        default: begin
          case (bsel)
            2'd0:    rbyte_v = live_reg[fld][7:0];
            2'd1:    rbyte_v = live_reg[fld][15:8];
            default: rbyte_v = live_reg[fld][23:16];
          endcase
        end
      endcase
    end

    assign hit_vec[gi]              = hit;
    assign rbyte_flat[gi*8 +: 8]    = rbyte_v;
    assign Gate[gi]                 = gate_reg;
    assign WaveType[gi*2 +: 2]      = wave_reg;
    assign Linear[gi]               = linear_reg;
    assign Incr[gi*24 +: 24]        = live_reg[0];
    assign PulseWidth[gi*24 +: 24]  = live_reg[1];
    assign Attack[gi*24 +: 24]      = live_reg[2];
    assign Decay[gi*24 +: 24]       = live_reg[3];
    assign Sustain[gi*24 +: 24]     = live_reg[4];
    assign Release[gi*24 +: 24]     = live_reg[5];
  end

  always_comb begin
    rdata_next  = 8'h00;
    mapped_next = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (hit_vec[i]) begin
        rdata_next  = rbyte_flat[i*8 +: 8];
        mapped_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdata_reg  <= 8'h00;
      mapped_reg <= 1'b0;
    end else if (strobe_reg) begin
      rdata_reg  <= rdata_next;
      mapped_reg <= mapped_next;
    end
  end

  assign BusData = (!BusReadWrite && mapped_reg) ? rdata_reg : 8'hzz;

endmodule
